mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one 32-bit memory port between two requesters: instruction fetch (port 0) and data access (port 1).
- Grants the port round-robin, one transaction at a time.
- Registers the winner's address and write data and drives them to memory.
- Completes each transaction with a one-cycle ack (with error flag and read data) to the owning requester; sits between the IF/MEM pipeline stages and the single memory interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles of asserted mem_req without mem_ack before error completion; range 1..65535.
- DW, 32: data/address width.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  transaction request, held until ack.
- addr0 / addr1  in  DW  byte address.
- we0 / we1  in  1  1 = write, 0 = read.
- wdata0 / wdata1  in  DW  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err  out  1  valid with ackN; 1 = timeout.
- rdata  out  DW  read data, valid with ackN.
- mem_req  out  1  memory request, held until mem_ack or timeout.
- mem_addr, mem_wdata  out  DW  registered address and write data.
- mem_we  out  1  registered write enable.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  DW  valid with mem_ack.

## Operation
- FSM states: IDLE, BUSY0, BUSY1, DONE.
- IDLE:
  - Only req0 set → capture addr0/we0/wdata0 into the mem_* registers, go to BUSY0.
  - Only req1 set → same with port 1, go to BUSY1.
  - Both set → grant the port that is not last_grant, then update last_grant.
  - Neither set → stay in IDLE.
- BUSYx: mem_req = 1 and mem_* held stable.
  - mem_ack → capture mem_rdata, err = 0, go to DONE.
  - Timeout counter reaches TIMEOUT_CYCLES → rdata = 0, err = 1, go to DONE; mem_req drops the same cycle.
- DONE: ackx = 1 for exactly this cycle, then go to IDLE.
- A requester dropping reqx during BUSYx is ignored: the transaction still completes and ackx still pulses.
- mem_ack in IDLE or DONE is ignored.
- mem_ack in the same cycle the timeout counter expires counts as success (err = 0).
- rdata and err hold their values until the next completion.
- rdata for writes is the captured mem_rdata; it has no meaning to the requester.

## Timing
- Reset values:
  - All outputs 0, including mem_addr/mem_wdata/rdata.
  - State IDLE, timeout counter 0.
  - last_grant = 1, so port 0 wins the first tie.
- reset asserted mid-transaction: mem_req and ackx drop on the next edge and the transaction is abandoned, with no ack.
- Latency:
  - reqx sampled high at edge 0 in IDLE → mem_req high after edge 0.
  - mem_ack sampled at edge k → ackx high for the cycle after edge k.
  - Minimum request-to-ack: 3 cycles (mem_ack in the first BUSY cycle).
- Back-to-back: the DONE→IDLE transition costs one cycle, so the next grant is sampled one cycle after the ack cycle.
  - A requester that keeps reqx high after its ack starts a new transaction.
  - That new transaction still obeys round-robin against the other port.
- Timeout counter:
  - Increments each BUSY cycle without mem_ack, starting at 1 in the first BUSY cycle.
  - Expires when count == TIMEOUT_CYCLES.
  - Clears on entry to IDLE.
- Timeout is used for err only; it does not change last_grant.

## Structure
- Shared package mem_arb_pkg: state encoding (IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2, DONE = 2'd3), DW default, timeout counter width (16).
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: gnt_valid, gnt_id.
  - Reused later for register-file write-port sharing.
- Address/write-data steering is a 2:1 DW-bit select on gnt_id, registered into mem_addr/mem_wdata.

## Test plan
- Single read: req0 = 1, addr0 = 0x0000_0040, memory acks 2 cycles after mem_req with 0xDEAD_BEEF → mem_addr = 0x40, mem_we = 0, ack0 pulses once, rdata = 0xDEAD_BEEF, err = 0, ack1 stays 0.
- Tie after reset: req0 and req1 both held, immediate acks → grant order 0,1,0,1 across four transactions; mem_addr alternates addr0/addr1; each ack is one cycle.
- Write on port 1: req1 = 1, we1 = 1, addr1 = 0x1000, wdata1 = 0x1234_5678 → mem_we = 1, mem_wdata = 0x1234_5678 stable until mem_ack, then ack1 pulses.
- Timeout: TIMEOUT_CYCLES = 4, req0, memory never acks → mem_req high exactly 4 cycles; ack0 with err = 1, rdata = 0; a subsequent req1 is granted normally.
- Reset mid-transaction: reset for one cycle during BUSY1 → mem_req = 0 and all outputs 0 next cycle, no ack1; a later tie grants port 0 first.
- Stray and coincident acks:
  - mem_ack pulsed in IDLE → no ack, state unchanged.
  - mem_ack in the timeout-expiry cycle → err = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and widths.
package mem_arb_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that did not
// win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;
    assign gnt_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port 0) and data access
// (port 1), one transaction at a time, with a cycle-count timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DW             = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic          we0,
    input  logic          we1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             gnt_valid;
    logic             gnt_id;
    logic             timeout_hit;
    logic [DW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_we;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_addr    = gnt_id ? addr1  : addr0;
    assign sel_wdata   = gnt_id ? wdata1 : wdata0;
    assign sel_we      = gnt_id ? we1    : we0;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (gnt_valid) state_nxt = gnt_id ? BUSY1 : BUSY0;
            BUSY0, BUSY1: if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE:         state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // last_grant doubles as the owner of the transaction in flight.
    always_comb begin
        mem_req = (state == BUSY0) || (state == BUSY1);
        ack0    = (state == DONE) && !last_grant;
        ack1    = (state == DONE) && last_grant;
    end

    // NOTE: all datapath registers are reset here; this is a handful of flops,
    // not a memory array, so resetting them costs nothing meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (gnt_valid) begin
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_we     <= sel_we;
                        last_grant <= gnt_id;
                        cnt        <= CNT_W'(1);
                    end
                end
                BUSY0, BUSY1: begin
                    // A late ack in the expiry cycle still counts as success.
                    if (mem_ack) begin
                        rdata <= mem_rdata;
                        err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES = 4; inputs change
// and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .we0       (we0),
        .we1       (we1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_ack = 0; mem_rdata = '0;
        step(); step();
        reset = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);

        // Tie after reset: immediate acks, expected grant order 0,1,0,1.
        req0 = 1; addr0 = 32'h100; req1 = 1; addr1 = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            check("tie_mem_req", 32'(mem_req), 32'd1);
            check("tie_mem_addr", mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            mem_ack = 1; mem_rdata = 32'hA000_0000 + 32'(i);
            step();
            mem_ack = 0;
            check("tie_ack0", 32'(ack0), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("tie_ack1", 32'(ack1), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("tie_rdata", rdata, 32'hA000_0000 + 32'(i));
            check("tie_mem_req_drop", 32'(mem_req), 32'd0);
            step();
            check("tie_ack_one_cycle", 32'({ack1, ack0}), 32'd0);
        end
        req0 = 0; req1 = 0;

        // Single read on port 0, memory acks in the second busy cycle.
        req0 = 1; addr0 = 32'h0000_0040; we0 = 0;
        step();
        check("rd_mem_req", 32'(mem_req), 32'd1);
        check("rd_mem_addr", mem_addr, 32'h40);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        step();
        check("rd_wait_mem_req", 32'(mem_req), 32'd1);
        check("rd_wait_ack0", 32'(ack0), 32'd0);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 0;
        check("rd_ack0", 32'(ack0), 32'd1);
        check("rd_ack1", 32'(ack1), 32'd0);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_err", 32'(err), 32'd0);
        req0 = 0;
        step();
        check("rd_ack0_off", 32'(ack0), 32'd0);

        // Stray ack while idle.
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 0;
        check("stray_mem_req", 32'(mem_req), 32'd0);
        check("stray_acks", 32'({ack1, ack0}), 32'd0);
        check("stray_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Write on port 1; requester drops req1 and changes wdata1 mid-transaction.
        req1 = 1; we1 = 1; addr1 = 32'h1000; wdata1 = 32'h1234_5678;
        step();
        check("wr_mem_req", 32'(mem_req), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", mem_addr, 32'h1000);
        check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        req1 = 0; wdata1 = 32'hFFFF_0000;
        step();
        check("wr_hold_mem_req", 32'(mem_req), 32'd1);
        check("wr_hold_wdata", mem_wdata, 32'h1234_5678);
        mem_ack = 1; mem_rdata = 32'h0000_0055;
        step();
        mem_ack = 0; we1 = 0;
        check("wr_ack1", 32'(ack1), 32'd1);
        check("wr_ack0", 32'(ack0), 32'd0);
        check("wr_err", 32'(err), 32'd0);
        step();
        check("wr_ack1_off", 32'(ack1), 32'd0);

        // Timeout on port 0: mem_req high exactly 4 cycles.
        req0 = 1; addr0 = 32'h80;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("to_mem_req_high", 32'(mem_req), 32'd1);
            check("to_no_ack", 32'(ack0), 32'd0);
        end
        step();
        check("to_mem_req_low", 32'(mem_req), 32'd0);
        check("to_ack0", 32'(ack0), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_rdata", rdata, 32'h0);
        req0 = 0; req1 = 1; addr1 = 32'h2000;
        step();
        check("to_ack0_off", 32'(ack0), 32'd0);
        check("to_err_hold", 32'(err), 32'd1);
        step();
        check("after_to_mem_req", 32'(mem_req), 32'd1);
        check("after_to_mem_addr", mem_addr, 32'h2000);
        mem_ack = 1; mem_rdata = 32'hCAFE_0001;
        step();
        mem_ack = 0; req1 = 0;
        check("after_to_ack1", 32'(ack1), 32'd1);
        check("after_to_err", 32'(err), 32'd0);
        check("after_to_rdata", rdata, 32'hCAFE_0001);
        step();

        // Reset during BUSY1 abandons the transaction.
        req1 = 1; addr1 = 32'h3000;
        step();
        check("rstmid_busy", 32'(mem_req), 32'd1);
        reset = 1; req1 = 0;
        step();
        reset = 0;
        check("rstmid_mem_req", 32'(mem_req), 32'd0);
        check("rstmid_ack1", 32'(ack1), 32'd0);
        check("rstmid_mem_addr", mem_addr, 32'h0);
        check("rstmid_rdata", rdata, 32'h0);
        check("rstmid_err", 32'(err), 32'd0);
        step();
        check("rstmid_no_ack", 32'({ack1, ack0}), 32'd0);

        // Tie after reset grants port 0; ack arrives in the expiry cycle.
        req0 = 1; addr0 = 32'h4000; req1 = 1; addr1 = 32'h5000;
        step();
        check("tie2_mem_addr", mem_addr, 32'h4000);
        step(); step(); step();
        check("coinc_mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 0; req0 = 0;
        check("coinc_ack0", 32'(ack0), 32'd1);
        check("coinc_err", 32'(err), 32'd0);
        check("coinc_rdata", rdata, 32'h0BAD_F00D);
        step();
        step();
        check("tie2_second_addr", mem_addr, 32'h5000);
        mem_ack = 1; mem_rdata = 32'h7777_0000;
        step();
        mem_ack = 0; req1 = 0;
        check("tie2_ack1", 32'(ack1), 32'd1);
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
